// File: rtl/mdu_sequencer.sv
// ---------------------------------------------------------------------------
// mdu_sequencer : iterative RV32M multiply/divide sequencer for Execute
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StartE,
   input  logic [2:0]      MDUOpE,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            FlushE,
   output logic            StallMDU,
   output logic            MDUDoneE,
   output logic [XLEN-1:0] MDUResultE
);

   localparam int                CNT_W    = $clog2(XLEN);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(XLEN - 1);
   localparam logic [2:0]        OP_MUL   = 3'b000;
   localparam logic [2:0]        OP_MULHU = 3'b011;
   localparam logic [XLEN-1:0]   INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     divs_q, divs_d;
   logic [2:0]          op_q, op_d;
   logic                negq_q, negq_d;
   logic                negr_q, negr_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic                done_q, done_d;

   // Start-cycle operand decode
   logic            is_div, a_signed, b_signed, sign_a, sign_b;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, special_res;

   assign is_div   = MDUOpE[2];
   assign a_signed = is_div ? ~MDUOpE[0] : (MDUOpE != OP_MULHU);
   assign b_signed = is_div ? ~MDUOpE[0] : ~MDUOpE[1];
   assign sign_a   = a_signed & SrcAE[XLEN-1];
   assign sign_b   = b_signed & SrcBE[XLEN-1];
   assign mag_a    = sign_a ? -SrcAE : SrcAE;
   assign mag_b    = sign_b ? -SrcBE : SrcBE;
   assign div_zero = is_div & (SrcBE == '0);
   assign div_ovf  = is_div & ~MDUOpE[0] & (SrcAE == INT_MIN) & (SrcBE == '1);

   always_comb begin
      special_res = '0;
      if (div_zero) begin
         special_res = MDUOpE[1] ? SrcAE : '1;
      end else if (div_ovf) begin
         special_res = MDUOpE[1] ? '0 : INT_MIN;
      end
   end

   // One iteration: shift-add for multiply, restoring subtract for divide.
   // For divide acc holds {remainder, quotient-in-progress}.
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;
   logic [XLEN-1:0]   rem_diff;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] step_next;

   assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, divs_q} : '0);
   assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
   assign rem_sh    = acc_q[2*XLEN-1:XLEN-1];
   assign rem_ge    = rem_sh >= {1'b0, divs_q};
   assign rem_diff  = rem_sh[XLEN-1:0] - divs_q;
   assign div_next  = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
   assign step_next = op_q[2] ? div_next : mul_next;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

   assign prod_fix = negq_q ? -step_next : step_next;
   assign quo_fix  = negq_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
   assign rem_fix  = negr_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];

   always_comb begin
      final_res = '0;
      if (op_q[2]) begin
         final_res = op_q[1] ? rem_fix : quo_fix;
      end else begin
         final_res = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      divs_d   = divs_q;
      op_d     = op_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      res_d    = res_q;
      StallMDU = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (StartE && !FlushE) begin
               StallMDU = 1'b1;
               op_d     = MDUOpE;
               acc_d    = {{XLEN{1'b0}}, mag_a};
               divs_d   = mag_b;
               negq_d   = sign_a ^ sign_b;
               negr_d   = sign_a;
               cnt_d    = '0;
               if (div_zero || div_ovf) begin
                  res_d   = special_res;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            StallMDU = 1'b1;
            acc_d    = step_next;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               res_d   = final_res;
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // A still-asserted StartE here belongs to the retiring instruction.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (FlushE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         res_d   = res_q;
      end

      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         divs_q  <= '0;
         op_q    <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         res_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         divs_q  <= divs_d;
         op_q    <= op_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

   assign MDUDoneE   = done_q;
   assign MDUResultE = res_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdu_sequencer : directed + scoreboarded bench for mdu_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        StartE;
   logic [2:0]  MDUOpE;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic        FlushE;
   logic        StallMDU;
   logic        MDUDoneE;
   logic [31:0] MDUResultE;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] sb_q[$];
   logic [31:0] last_res = '0;

   always #5 clk = ~clk;

   mdu_sequencer #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .StartE     (StartE),
      .MDUOpE     (MDUOpE),
      .SrcAE      (SrcAE),
      .SrcBE      (SrcBE),
      .FlushE     (FlushE),
      .StallMDU   (StallMDU),
      .MDUDoneE   (MDUDoneE),
      .MDUResultE (MDUResultE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Independent reference built on native 64-bit and signed arithmetic
   function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ax, bx, p;
      ax = (op == 3'd3) ? {32'b0, a} : {{32{a[31]}}, a};
      bx = op[1] ? {32'b0, b} : {{32{b[31]}}, b};
      p  = ax * bx;
      if (op == 3'd0) return p[31:0];
      if (!op[2])     return p[63:32];
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      case (op)
         3'd4:    return $signed(a) / $signed(b);
         3'd5:    return a / b;
         3'd6:    return $signed(a) % $signed(b);
         default: return a % b;
      endcase
   endfunction

   // Drive one operation starting this cycle; check stall/done every cycle
   // and pop the scoreboard in the cycle the result is due.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit toggle, input bit keep_start);
      int          lat;
      bit          special;
      logic [31:0] e;
      special = op[2] && (b == 32'd0 ||
                (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat = special ? 1 : 33;
      sb_q.push_back(exp);
      StartE = 1'b1;
      FlushE = 1'b0;
      MDUOpE = op;
      SrcAE  = a;
      SrcBE  = b;
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         chk($sformatf("stall op%0d k%0d", op, k), 32'(StallMDU), 32'(k < lat));
         chk($sformatf("done op%0d k%0d", op, k), 32'(MDUDoneE), 32'(k == lat));
         if (k == lat) begin
            e = sb_q.pop_front();
            chk($sformatf("result op%0d a=%h b=%h", op, a, b), MDUResultE, e);
            last_res = e;
         end
         next_cycle();
         if (toggle && k < lat) begin
            SrcAE = $urandom;
            SrcBE = $urandom;
         end
      end
      if (!keep_start) begin
         StartE = 1'b0;
         @(negedge clk);
         chk("post-done stall", 32'(StallMDU), 32'd0);
         chk("post-done done", 32'(MDUDoneE), 32'd0);
         next_cycle();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      rst    = 1'b0;
      StartE = 1'b0;
      FlushE = 1'b0;
      MDUOpE = 3'd0;
      SrcAE  = '0;
      SrcBE  = '0;
      #2;
      chk("reset stall", 32'(StallMDU), 32'd0);
      chk("reset done", 32'(MDUDoneE), 32'd0);
      chk("reset result", MDUResultE, 32'd0);
      next_cycle();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle stall", 32'(StallMDU), 32'd0);
         chk("idle done", 32'(MDUDoneE), 32'd0);
         chk("idle result", MDUResultE, 32'd0);
         next_cycle();
      end

      // Multiplies
      run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0);
      run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0, 1'b0);
      run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);

      // Divides with operand changes during the stall
      run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b1, 1'b0);
      run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b1, 1'b0);
      run_op(3'd5, 32'd100,        32'd7,         32'd14,        1'b1, 1'b0);
      run_op(3'd7, 32'd100,        32'd7,         32'd2,         1'b1, 1'b0);

      // Divide special cases finish one cycle after start
      run_op(3'd5, 32'd100,        32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0);
      run_op(3'd6, 32'd100,        32'd0,         32'd100,       1'b0, 1'b0);
      run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
      run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0);
      run_op(3'd7, 32'd100,        32'd7,         32'd2,         1'b0, 1'b0);

      // Flush at T+10 of a DIV
      StartE = 1'b1;
      MDUOpE = 3'd4;
      SrcAE  = 32'd1000;
      SrcBE  = 32'd3;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("flush pre stall", 32'(StallMDU), 32'd1);
         chk("flush pre done", 32'(MDUDoneE), 32'd0);
         next_cycle();
      end
      FlushE = 1'b1;
      next_cycle();
      FlushE = 1'b0;
      StartE = 1'b0;
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         chk("flush stall", 32'(StallMDU), 32'd0);
         chk("flush done", 32'(MDUDoneE), 32'd0);
         chk("flush result", MDUResultE, last_res);
         next_cycle();
      end

      // FlushE with StartE in IDLE: no start
      StartE = 1'b1;
      FlushE = 1'b1;
      MDUOpE = 3'd0;
      @(negedge clk);
      chk("flush+start stall", 32'(StallMDU), 32'd0);
      next_cycle();
      StartE = 1'b0;
      FlushE = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("flush+start after stall", 32'(StallMDU), 32'd0);
         chk("flush+start after done", 32'(MDUDoneE), 32'd0);
         next_cycle();
      end

      // Randomised operations checked against the reference
      for (int i = 0; i < 8; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 3 == 0) rb = rb & 32'h0000_000F;
         run_op(rop, ra, rb, ref_mdu(rop, ra, rb), 1'b1, 1'b0);
      end

      // Back-to-back multiplies: second start at T+34, done at T+67
      run_op(3'd0, 32'd12345,      32'd678,       32'd8369910,   1'b0, 1'b1);
      run_op(3'd1, 32'hFFFF_FFFF,  32'd5,         32'hFFFF_FFFF, 1'b0, 1'b0);

      // Reset asserted at T+5 of a back-to-back second multiply
      run_op(3'd3, 32'h0001_0000,  32'h0001_0000, 32'd1,         1'b0, 1'b1);
      MDUOpE = 3'd0;
      SrcAE  = 32'd9;
      SrcBE  = 32'd9;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort pre stall", 32'(StallMDU), 32'd1);
         chk("abort pre done", 32'(MDUDoneE), 32'd0);
         next_cycle();
      end
      rst    = 1'b0;
      StartE = 1'b0;
      #1;
      chk("abort stall", 32'(StallMDU), 32'd0);
      chk("abort done", 32'(MDUDoneE), 32'd0);
      chk("abort result", MDUResultE, 32'd0);
      next_cycle();
      next_cycle();
      rst = 1'b1;
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         chk("post-abort stall", 32'(StallMDU), 32'd0);
         chk("post-abort done", 32'(MDUDoneE), 32'd0);
         chk("post-abort result", MDUResultE, 32'd0);
         next_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
